wave_ram_arbiter: RTL
=====================

Name: wave_ram_arbiter

Overview:
Shares the single-port 512x8 wave sample RAM between the capture writer and the wave display reader. Display reads have priority; capture writes are buffered in a one-entry holding register and promoted after a bounded wait. Sits between wave_capture, wave_display and the sample RAM macro. Replaces the dual-port RAM so the design fits a single-port block.

Parameters:
ADDR_WIDTH, 9, RAM address width (two 256-entry halves).
DATA_WIDTH, 8, sample width.
STARVE_LIMIT, 4, consecutive lost arbitration cycles after which a pending write beats a read (1..15).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (0 = reset)
wr_valid  input  1  capture write request
wr_addr  input  ADDR_WIDTH  capture write address
wr_data  input  DATA_WIDTH  capture write sample
wr_ready  output  1  write accepted this cycle when wr_valid=1
rd_req  input  1  display read request; held until rd_gnt
rd_addr  input  ADDR_WIDTH  display read address; stable while rd_req=1
rd_gnt  output  1  read issued to RAM this cycle
rd_data_valid  output  1  rd_data valid (one cycle after rd_gnt)
rd_data  output  DATA_WIDTH  read sample (passthrough of ram_rdata)
ram_en  output  1  RAM access enable
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_WIDTH  RAM address
ram_wdata  output  DATA_WIDTH  RAM write data
ram_rdata  input  DATA_WIDTH  RAM read data, synchronous, 1-cycle latency
wr_stall_cnt  output  8  saturating count of cycles a pending write lost arbitration

Behaviour:
- State: hold_full, hold_addr, hold_data, starve_cnt (4b), rd_data_valid, wr_stall_cnt.
- Reset (reset=0 at a clk edge): hold_full=0, hold_addr/hold_data=0, starve_cnt=0, rd_data_valid=0, wr_stall_cnt=0. While reset=0: rd_gnt=0, ram_en=0, ram_we=0, wr_ready=0. Reset mid-operation drops any held write and any in-flight read (rd_data_valid=0 next cycle).
- Grant logic is combinational each cycle from hold_full, rd_req and starve_cnt:
  - Write grant (wg) = hold_full & (~rd_req | starve_cnt==STARVE_LIMIT | hold_addr==rd_addr).
  - Read grant (rd_gnt) = rd_req & ~wg.
  - The same-address rule makes a read after a pending write to the same address return the new data.
- RAM drive:
  - wg: ram_en=1, ram_we=1, ram_addr=hold_addr, ram_wdata=hold_data.
  - rd_gnt: ram_en=1, ram_we=0, ram_addr=rd_addr.
  - Neither: ram_en=0, ram_we=0, ram_addr and ram_wdata hold their last driven values (no toggling).
- wr_ready = reset & (~hold_full | wg). Accept when wr_valid & wr_ready: hold_addr, hold_data <= wr_addr, wr_data; hold_full <= 1.
- hold_full next value: set on accept; otherwise cleared on wg; otherwise unchanged. Accept and wg in the same cycle gives back-to-back writes at 1 per cycle when no reads are pending.
- starve_cnt: cleared on wg or when hold_full=0. Incremented when hold_full & rd_gnt. It never exceeds STARVE_LIMIT.
- wr_stall_cnt: increments when hold_full & rd_gnt; saturates at 255; cleared only by reset.
- rd_data_valid <= rd_gnt (1-cycle latency). rd_data = ram_rdata, combinational.
- A continuous rd_req stream therefore gets at most STARVE_LIMIT consecutive grants before a pending write is forced in. Worst-case write latency from accept to RAM write is STARVE_LIMIT+1 cycles.
- rd_req deasserted without rd_gnt is a protocol violation. Changing rd_addr while rd_req=1 and rd_gnt=0 is also a protocol violation. Both are flagged by bench assertions; RTL behaviour is undefined.

Test Plan:
- Reset: hold reset=0 for 3 cycles with wr_valid=1 and rd_req=1 -> wr_ready=0, rd_gnt=0, ram_en=0, rd_data_valid=0, wr_stall_cnt=0.
- Write only: wr_valid=1 for 4 cycles, addr 0x100..0x103, data 0xA0..0xA3 -> wr_ready=1 every cycle; ram_we=1 on cycles 2..5 with matching addr/data; hold_full=0 after.
- Read latency: preload addr 0x005=0x5C, then rd_req at 0x005 -> rd_gnt same cycle, rd_data_valid=1 and rd_data=0x5C next cycle.
- Starvation (STARVE_LIMIT=4): continuous rd_req at 0x010 plus one write to 0x020 -> 4 read grants, write issued on 5th cycle, wr_stall_cnt=4, rd_gnt=0 that cycle, reads resume.
- Same-address hazard: hold write 0x033=0x77 pending, rd_req 0x033 same cycle -> write first, read next cycle, rd_data=0x77, starve_cnt not incremented.
- Reset mid-operation: hold_full=1 and read in flight, reset=0 for 1 cycle -> held write never reaches RAM, rd_data_valid=0 next cycle, wr_ready=1 after release.

Source files
------------

// File: rtl/wave_ram_arbiter.sv
// Single-port wave RAM arbiter: display reads win, capture writes wait in a
// one-entry holding register and are forced in after STARVE_LIMIT lost cycles.
module wave_ram_arbiter #(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_data_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [7:0]            wr_stall_cnt
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  wr_req_t               hold;
  logic                  hold_full;
  logic [3:0]            starve_cnt;
  logic                  wg;
  logic                  accept;
  logic                  addr_match;
  logic                  starve_hit;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [DATA_WIDTH-1:0] last_wdata;

  // Same-address forcing keeps read-after-write ordering without a bypass path.
  assign addr_match = (hold.addr == rd_addr);
  assign starve_hit = (starve_cnt == 4'(STARVE_LIMIT));

  always_comb begin
    wg       = reset & hold_full & (~rd_req | starve_hit | addr_match);
    rd_gnt   = reset & rd_req & ~wg;
    wr_ready = reset & (~hold_full | wg);
    accept   = wr_valid & wr_ready;
  end

  // Idle cycles park address/data on the last driven value to avoid toggling.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = last_addr;
    ram_wdata = last_wdata;
    if (wg) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = hold.addr;
      ram_wdata = hold.data;
    end else if (rd_gnt) begin
      ram_en   = 1'b1;
      ram_addr = rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_en) last_addr  <= ram_addr;
    if (ram_we) last_wdata <= ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold          <= '0;
      hold_full     <= 1'b0;
      starve_cnt    <= '0;
      rd_data_valid <= 1'b0;
      wr_stall_cnt  <= '0;
    end else begin
      if (accept) begin
        hold.addr <= wr_addr;
        hold.data <= wr_data;
        hold_full <= 1'b1;
      end else if (wg) begin
        hold_full <= 1'b0;
      end
      if (wg || !hold_full)
        starve_cnt <= '0;
      else if (rd_gnt && starve_cnt < 4'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 4'd1;
      if (hold_full && rd_gnt && wr_stall_cnt != 8'hFF)
        wr_stall_cnt <= wr_stall_cnt + 8'd1;
      rd_data_valid <= rd_gnt;
    end
  end

  assign rd_data = ram_rdata;

endmodule
